// File: rtl/decomp_pkg.sv
// Shared types and helpers for the decompression packet dispatcher.
// Mode encoding, engine count and header decode used by the top and the order FIFO.
package decomp_pkg;

    localparam int ENG_N  = 3;
    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        BPC = 2'd0,
        ZRL = 2'd1,
        SR  = 2'd2
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        PKT  = 1'b1
    } in_state_e;

    function automatic mode_e decode_mode(input logic [MODE_W-1:0] hdr);
        case (hdr)
            2'b00:   return BPC;
            2'b01:   return ZRL;
            default: return SR;
        endcase
    endfunction

endpackage

// File: rtl/decomp_order_fifo.sv
// Synchronous FIFO that remembers which engine owns each in-flight packet.
// Simultaneous push and pop are allowed; a pop frees the slot a same-cycle push needs.
module decomp_order_fifo
    import decomp_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = MODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/decomp_dispatch.sv
// Steers packets to the BPC/ZRL/SR engines by header mode and merges replies in arrival order.
// Define DECOMP_PERF_CNT_EN to add per-mode accepted-packet counters (cnt_bpc/cnt_zrl/cnt_sr).
module decomp_dispatch
    import decomp_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ORD_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    s_valid,
    input  logic                    s_sop,
    input  logic                    s_eop,
    output logic                    s_ready,
    output logic [ENG_N*DATA_W-1:0] eng_data_o,
    output logic [ENG_N-1:0]        eng_valid_o,
    output logic [ENG_N-1:0]        eng_sop_o,
    output logic [ENG_N-1:0]        eng_eop_o,
    input  logic [ENG_N-1:0]        eng_ready_i,
    input  logic [ENG_N*DATA_W-1:0] eng_data_i,
    input  logic [ENG_N-1:0]        eng_valid_i,
    input  logic [ENG_N-1:0]        eng_sop_i,
    input  logic [ENG_N-1:0]        eng_eop_i,
    output logic [ENG_N-1:0]        eng_ready_o,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_valid,
    output logic                    m_sop,
    output logic                    m_eop,
    input  logic                    m_ready,
    output logic                    proto_err
`ifdef DECOMP_PERF_CNT_EN
    ,
    output logic [31:0]             cnt_bpc,
    output logic [31:0]             cnt_zrl,
    output logic [31:0]             cnt_sr
`endif
);

    in_state_e         state, state_nxt;
    mode_e             sel, sel_lat;
    logic              in_rdy, fwd, drop, push, pkt_sop_err;
    logic [MODE_W-1:0] head;
    logic              ord_full, ord_empty;
    logic              out_rdy, eng_fire, pop;
    logic [DATA_W-1:0] in_data;
    logic              in_sop, in_eop;
    logic              skid_vld_p1;
    logic [DATA_W-1:0] skid_data_p1;
    logic              skid_sop_p1, skid_eop_p1;

    // Input side: header decode on the first beat, then the packet sticks to its engine
    always_comb begin
        state_nxt   = state;
        sel         = sel_lat;
        in_rdy      = 1'b0;
        fwd         = 1'b0;
        drop        = 1'b0;
        push        = 1'b0;
        pkt_sop_err = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    sel = decode_mode(s_data[DATA_W-1 -: MODE_W]);
                    if (s_sop) begin
                        in_rdy = eng_ready_i[sel] & ~ord_full;
                        fwd    = s_valid & in_rdy;
                        push   = fwd;
                        if (fwd && !s_eop) state_nxt = PKT;
                    end else begin
                        in_rdy = 1'b1;
                        drop   = s_valid;
                    end
                end
                PKT: begin
                    in_rdy      = eng_ready_i[sel];
                    fwd         = s_valid & in_rdy;
                    pkt_sop_err = fwd & s_sop;
                    if (fwd && s_eop) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign s_ready     = in_rdy;
    assign eng_valid_o = fwd ? (ENG_N'(1) << sel) : '0;
    assign eng_data_o  = {ENG_N{s_data}};
    assign eng_sop_o   = {ENG_N{s_sop}};
    assign eng_eop_o   = {ENG_N{s_eop}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel_lat   <= BPC;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (push) sel_lat <= sel;
            if (drop || pkt_sop_err) proto_err <= 1'b1;
        end
    end

    decomp_order_fifo #(
        .DEPTH  (ORD_DEPTH),
        .DATA_W (MODE_W)
    ) u_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (sel),
        .pop   (pop),
        .dout  (head),
        .full  (ord_full),
        .empty (ord_empty)
    );

    // Return side: only the oldest packet's engine may hand beats back
    assign out_rdy     = ~rst & ~ord_empty & ~skid_vld_p1;
    assign eng_ready_o = out_rdy ? (ENG_N'(1) << head) : '0;
    assign in_data     = eng_data_i[int'(head)*DATA_W +: DATA_W];
    assign in_sop      = eng_sop_i[head];
    assign in_eop      = eng_eop_i[head];
    assign eng_fire    = out_rdy & eng_valid_i[head];
    assign pop         = eng_fire & in_eop;

    // Output register plus one skid entry that absorbs the beat in flight when m_ready drops
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid     <= 1'b0;
            m_sop       <= 1'b0;
            m_eop       <= 1'b0;
            m_data      <= '0;
            skid_vld_p1 <= 1'b0;
        end else if (!m_valid || m_ready) begin
            if (skid_vld_p1) begin
                m_valid     <= 1'b1;
                m_data      <= skid_data_p1;
                m_sop       <= skid_sop_p1;
                m_eop       <= skid_eop_p1;
                skid_vld_p1 <= 1'b0;
            end else begin
                m_valid <= eng_fire;
                m_sop   <= eng_fire & in_sop;
                m_eop   <= eng_fire & in_eop;
                if (eng_fire) m_data <= in_data;
            end
        end else if (eng_fire) begin
            skid_vld_p1 <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (m_valid && !m_ready && eng_fire && !skid_vld_p1) begin
            skid_data_p1 <= in_data;
            skid_sop_p1  <= in_sop;
            skid_eop_p1  <= in_eop;
        end
    end

`ifdef DECOMP_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_bpc <= '0;
            cnt_zrl <= '0;
            cnt_sr  <= '0;
        end else if (push) begin
            case (sel)
                BPC:     cnt_bpc <= cnt_bpc + 32'd1;
                ZRL:     cnt_zrl <= cnt_zrl + 32'd1;
                default: cnt_sr  <= cnt_sr + 32'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_decomp_dispatch.sv
// Directed bench for decomp_dispatch with echo-engine models and an in-order scoreboard.
module tb_decomp_dispatch;

    logic         clk = 1'b0;
    logic         rst;
    logic [63:0]  s_data;
    logic         s_valid, s_sop, s_eop, s_ready;
    logic [191:0] eng_data_o;
    logic [2:0]   eng_valid_o, eng_sop_o, eng_eop_o, eng_ready_i;
    logic [191:0] eng_data_i;
    logic [2:0]   eng_valid_i, eng_sop_i, eng_eop_i, eng_ready_o;
    logic [63:0]  m_data;
    logic         m_valid, m_sop, m_eop, m_ready;
    logic         proto_err;
`ifdef DECOMP_PERF_CNT_EN
    logic [31:0]  cnt_bpc, cnt_zrl, cnt_sr;
`endif

    int           n_chk = 0;
    int           n_err = 0;
    logic [65:0]  eq0[$], eq1[$], eq2[$], exp_q[$];
    logic [2:0]   en;
    logic         rnd;
    logic         in_pkt;
    logic         last_sf;
    int           cur_mode;
    int           sops[3];
    int           n_in, n_out, n_sent;

    decomp_dispatch #(.DATA_W(64), .ORD_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
        .eng_data_o(eng_data_o), .eng_valid_o(eng_valid_o), .eng_sop_o(eng_sop_o),
        .eng_eop_o(eng_eop_o), .eng_ready_i(eng_ready_i),
        .eng_data_i(eng_data_i), .eng_valid_i(eng_valid_i), .eng_sop_i(eng_sop_i),
        .eng_eop_i(eng_eop_i), .eng_ready_o(eng_ready_o),
        .m_data(m_data), .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop), .m_ready(m_ready),
        .proto_err(proto_err)
`ifdef DECOMP_PERF_CNT_EN
        , .cnt_bpc(cnt_bpc), .cnt_zrl(cnt_zrl), .cnt_sr(cnt_sr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        assert (act === req) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, req);
        end
    endtask

    // Each engine echoes its beats XORed with its own tag, so misrouting shows up on m_data
    function automatic logic [63:0] tagf(input int i);
        case (i)
            0:       return 64'h0000_0000_0000_1100;
            1:       return 64'h0000_0000_2222_0000;
            default: return 64'h0033_0000_0000_0000;
        endcase
    endfunction

    function automatic int mode_of(input logic [63:0] d);
        if (d[63:62] == 2'b00) return 0;
        if (d[63:62] == 2'b01) return 1;
        return 2;
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return eq0.size();
            1:       return eq1.size();
            default: return eq2.size();
        endcase
    endfunction

    function automatic logic [65:0] qfront(input int i);
        case (i)
            0:       return eq0[0];
            1:       return eq1[0];
            default: return eq2[0];
        endcase
    endfunction

    task automatic qpop(input int i);
        case (i)
            0:       void'(eq0.pop_front());
            1:       void'(eq1.pop_front());
            default: void'(eq2.pop_front());
        endcase
    endtask

    task automatic qpush(input int i, input logic [65:0] v);
        case (i)
            0:       eq0.push_back(v);
            1:       eq1.push_back(v);
            default: eq2.push_back(v);
        endcase
    endtask

    task automatic drive_eng();
        for (int i = 0; i < 3; i++) begin
            logic [65:0] f;
            if (en[i] && qsize(i) > 0) begin
                f = qfront(i);
                eng_valid_i[i]           = 1'b1;
                eng_data_i[i*64 +: 64]   = f[65:2];
                eng_sop_i[i]             = f[1];
                eng_eop_i[i]             = f[0];
            end else begin
                eng_valid_i[i]           = 1'b0;
                eng_data_i[i*64 +: 64]   = '0;
                eng_sop_i[i]             = 1'b0;
                eng_eop_i[i]             = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic         rs, sf, mf, ss, se, ms, me;
        logic [2:0]   ev, ef, esop, eeop;
        logic [191:0] ed;
        logic [63:0]  sd, md;
        logic [65:0]  e;
        @(negedge clk);
        rs = rst; sf = s_valid & s_ready; mf = m_valid & m_ready;
        ev = eng_valid_o; ef = eng_valid_i & eng_ready_o;
        ed = eng_data_o; esop = eng_sop_o; eeop = eng_eop_o;
        sd = s_data; ss = s_sop; se = s_eop;
        md = m_data; ms = m_sop; me = m_eop;
        last_sf = sf;
        @(posedge clk);
        #1;
        if (rs) begin
            eq0.delete(); eq1.delete(); eq2.delete(); exp_q.delete();
            in_pkt = 1'b0; n_in = 0; n_out = 0;
            for (int i = 0; i < 3; i++) sops[i] = 0;
        end else begin
            if (sf && !in_pkt && !ss) begin
                chk("drop_no_fwd", 64'(ev), 64'(0));
            end else if (sf) begin
                if (!in_pkt) begin
                    cur_mode = mode_of(sd);
                    sops[cur_mode]++;
                end
                chk("route", 64'(ev), 64'(3'b001 << cur_mode));
                exp_q.push_back({sd ^ tagf(cur_mode), ss, se});
                n_in++;
                in_pkt = !se;
            end else begin
                chk("no_fwd", 64'(ev), 64'(0));
            end
            for (int i = 0; i < 3; i++) if (ef[i] && qsize(i) > 0) qpop(i);
            for (int i = 0; i < 3; i++)
                if (ev[i]) qpush(i, {ed[i*64 +: 64] ^ tagf(i), esop[i], eeop[i]});
            if (mf) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("m_data", md, e[65:2]);
                    chk("m_sop", 64'(ms), 64'(e[1]));
                    chk("m_eop", 64'(me), 64'(e[0]));
                    n_out++;
                end
            end
        end
        if (rnd) begin
            m_ready     = 1'($urandom_range(0, 1));
            eng_ready_i = 3'($urandom_range(0, 7));
        end
        drive_eng();
    endtask

    task automatic send(input logic [63:0] d, input logic sop, input logic eop);
        int waited;
        waited = 0;
        s_data = d; s_sop = sop; s_eop = eop; s_valid = 1'b1;
        do begin
            tick();
            waited++;
        end while (!last_sf && waited < 200);
        if (!last_sf) chk("send_timeout", 64'(last_sf), 64'(1));
        s_valid = 1'b0;
    endtask

    task automatic drain(input int lim);
        int g;
        g = 0;
        while (exp_q.size() > 0 && g < lim) begin
            tick();
            g++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; s_data = '0;
        eng_ready_i = 3'b111; eng_valid_i = '0; eng_data_i = '0; eng_sop_i = '0; eng_eop_i = '0;
        m_ready = 1'b1; en = 3'b111; rnd = 1'b0; in_pkt = 1'b0; last_sf = 1'b0;
        cur_mode = 0; n_in = 0; n_out = 0; n_sent = 0;
        for (int i = 0; i < 3; i++) sops[i] = 0;
        tick();
        tick();
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'(0));
        chk("rst_eng_valid_o", 64'(eng_valid_o), 64'(0));
        chk("rst_eng_ready_o", 64'(eng_ready_o), 64'(0));
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_sop", 64'(m_sop), 64'(0));
        chk("rst_m_eop", 64'(m_eop), 64'(0));
        chk("rst_m_data", m_data, 64'(0));
        chk("rst_proto_err", 64'(proto_err), 64'(0));
        rst = 1'b0;

        // 1: four-beat ZRL packet, echo one cycle behind
        for (int b = 0; b < 4; b++) begin
            s_data = 64'h4000_0000_0000_0010 + 64'(b);
            s_sop = (b == 0); s_eop = (b == 3); s_valid = 1'b1;
            #1;
            chk("t1_s_ready", 64'(s_ready), 64'(1));
            chk("t1_route_zrl", 64'(eng_valid_o), 64'(3'b010));
            tick();
            if (b == 0) chk("t1_eng_ready_o", 64'(eng_ready_o), 64'(3'b010));
            if (b >= 1) begin
                chk("t1_m_valid", 64'(m_valid), 64'(1));
                chk("t1_m_sop", 64'(m_sop), 64'(b == 1));
            end
            if (b == 1) chk("t1_m_data", m_data, 64'h4000_0000_2222_0010);
        end
        s_valid = 1'b0;
        tick();
        chk("t1_m_eop", 64'(m_eop), 64'(1));
        chk("t1_last_valid", 64'(m_valid), 64'(1));
        tick();
        chk("t1_m_idle", 64'(m_valid), 64'(0));

        // 2: BPC, SR, ZRL, SR with only the SR engine replying at first
        en = 3'b100; drive_eng();
        send(64'h0000_0000_0000_0A00, 1'b1, 1'b0); send(64'h0000_0000_0000_0A01, 1'b0, 1'b1);
        send(64'h8000_0000_0000_0B00, 1'b1, 1'b0); send(64'h8000_0000_0000_0B01, 1'b0, 1'b1);
        send(64'h4000_0000_0000_0C00, 1'b1, 1'b0); send(64'h4000_0000_0000_0C01, 1'b0, 1'b1);
        send(64'hC000_0000_0000_0D00, 1'b1, 1'b0); send(64'hC000_0000_0000_0D01, 1'b0, 1'b1);
        tick();
        chk("t2_hold_sr", 64'(eng_ready_o), 64'(3'b001));
        chk("t2_no_output", 64'(m_valid), 64'(0));
        en = 3'b111; drive_eng();
        tick();
        chk("t2_still_bpc", 64'(eng_ready_o), 64'(3'b001));
        tick();
        chk("t2_sr_next", 64'(eng_ready_o), 64'(3'b100));
        drain(100);

        // 3: order FIFO full with engines stalled
        en = 3'b000; drive_eng();
        send(64'h0000_0000_0000_1A00, 1'b1, 1'b0); send(64'h0000_0000_0000_1A01, 1'b0, 1'b1);
        send(64'h4000_0000_0000_1B00, 1'b1, 1'b1);
        send(64'h8000_0000_0000_1C00, 1'b1, 1'b1);
        send(64'h0000_0000_0000_1D00, 1'b1, 1'b0);
        s_data = 64'h0000_0000_0000_1D01; s_sop = 1'b0; s_eop = 1'b0; s_valid = 1'b1;
        #1;
        chk("t3_body_ready", 64'(s_ready), 64'(1));
        tick();
        send(64'h0000_0000_0000_1D02, 1'b0, 1'b1);
        s_data = 64'h4000_0000_0000_1E00; s_sop = 1'b1; s_eop = 1'b1; s_valid = 1'b1;
        #1;
        chk("t3_full_block", 64'(s_ready), 64'(0));
        tick();
        chk("t3_full_block2", 64'(s_ready), 64'(0));
        en = 3'b111; drive_eng();
        tick();
        chk("t3_before_eop", 64'(s_ready), 64'(0));
        tick();
        chk("t3_after_eop", 64'(s_ready), 64'(1));
        tick();
        chk("t3_fifth_acc", 64'(last_sf), 64'(1));
        s_valid = 1'b0;
        drain(100);

        // 4: single-beat SR packet, then an immediate BPC sop
        s_data = 64'h8000_0000_0000_2A00; s_sop = 1'b1; s_eop = 1'b1; s_valid = 1'b1;
        #1;
        chk("t4_s_ready", 64'(s_ready), 64'(1));
        chk("t4_route_sr", 64'(eng_valid_o), 64'(3'b100));
        tick();
        s_data = 64'h0000_0000_0000_2B00; s_sop = 1'b1; s_eop = 1'b1;
        #1;
        chk("t4_next_ready", 64'(s_ready), 64'(1));
        chk("t4_next_bpc", 64'(eng_valid_o), 64'(3'b001));
        chk("t4_head_sr", 64'(eng_ready_o), 64'(3'b100));
        tick();
        s_valid = 1'b0;
        drain(100);

        // 5: stray body beat in IDLE
        s_data = 64'h0000_0000_0000_FFFF; s_sop = 1'b0; s_eop = 1'b0; s_valid = 1'b1;
        #1;
        chk("t5_s_ready", 64'(s_ready), 64'(1));
        chk("t5_no_fwd", 64'(eng_valid_o), 64'(0));
        tick();
        s_valid = 1'b0;
        chk("t5_proto_err", 64'(proto_err), 64'(1));
        tick();
        tick();
        chk("t5_proto_sticky", 64'(proto_err), 64'(1));
        chk("t5_nothing_out", 64'(exp_q.size()), 64'(0));

        // 6: reset in the middle of a packet with output backed up
        m_ready = 1'b0;
        send(64'h4000_0000_0000_3A00, 1'b1, 1'b0);
        send(64'h4000_0000_0000_3A01, 1'b0, 1'b0);
        tick();
        chk("t6_pre_valid", 64'(m_valid), 64'(1));
        rst = 1'b1;
        tick();
        chk("t6_s_ready", 64'(s_ready), 64'(0));
        chk("t6_eng_valid_o", 64'(eng_valid_o), 64'(0));
        chk("t6_eng_ready_o", 64'(eng_ready_o), 64'(0));
        chk("t6_m_valid", 64'(m_valid), 64'(0));
        chk("t6_m_sop", 64'(m_sop), 64'(0));
        chk("t6_m_eop", 64'(m_eop), 64'(0));
        chk("t6_m_data", m_data, 64'(0));
        chk("t6_proto_err", 64'(proto_err), 64'(0));
        rst = 1'b0; m_ready = 1'b1;
        #1;
        chk("t6_fifo_empty", 64'(eng_ready_o), 64'(0));
        s_data = 64'hC000_0000_0000_3B00; s_sop = 1'b1; s_eop = 1'b0; s_valid = 1'b1;
        #1;
        chk("t6_fresh_route", 64'(eng_valid_o), 64'(3'b100));
        tick();
        send(64'hC000_0000_0000_3B01, 1'b0, 1'b1);
        drain(100);

        // 7: random packets with m_ready and engine-ready toggling
        rnd = 1'b1;
        while (n_sent < 1000) begin
            int          len;
            logic [1:0]  hdr;
            len = $urandom_range(1, 6);
            hdr = 2'($urandom_range(0, 3));
            for (int b = 0; b < len; b++) begin
                send({hdr, 30'($urandom), 32'($urandom)}, (b == 0), (b == len - 1));
                n_sent++;
            end
        end
        rnd = 1'b0; m_ready = 1'b1; eng_ready_i = 3'b111; en = 3'b111; drive_eng();
        drain(1000);
        chk("t7_count", 64'(n_out), 64'(n_in));
`ifdef DECOMP_PERF_CNT_EN
        chk("cnt_bpc", 64'(cnt_bpc), 64'(sops[0]));
        chk("cnt_zrl", 64'(cnt_zrl), 64'(sops[1]));
        chk("cnt_sr", 64'(cnt_sr), 64'(sops[2]));
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
